// File: rtl/pdm_pkg.sv
// Shared types and default constants for the PDM sample path.
package pdm_pkg;

  localparam int unsigned PDM_BIT_WIDTH = 24;
  localparam int unsigned PDM_CLK_DIV   = 32;
  localparam int unsigned PDM_OSR       = 128;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} sched_state_t;

  typedef logic signed [PDM_BIT_WIDTH-1:0] pcm_sample_t;

endpackage

// File: rtl/pdm_sample_scheduler_if.sv
// PCM valid/ready handshake between the audio source and the sample scheduler.
interface pdm_sample_scheduler_if #(
  parameter int unsigned BIT_WIDTH = pdm_pkg::PDM_BIT_WIDTH
);

  logic signed [BIT_WIDTH-1:0] audio_in;
  logic                        audio_valid_in;
  logic                        audio_ready_out;

  modport master (output audio_in, output audio_valid_in, input audio_ready_out);
  modport slave  (input audio_in, input audio_valid_in, output audio_ready_out);

endinterface

// File: rtl/pdm_strobe_gen.sv
// Oversample divider and frame counter; drives the 50% duty pdm strobe.
module pdm_strobe_gen #(
  parameter int unsigned CLK_DIV = pdm_pkg::PDM_CLK_DIV,
  parameter int unsigned OSR     = pdm_pkg::PDM_OSR
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic start_in,
  input  logic advance_in,
  output logic frame_edge_out,
  output logic pdm_sample_out
);

  localparam int unsigned DivW  = $clog2(CLK_DIV);
  localparam int unsigned TickW = $clog2(OSR);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]  DivHalf  = DivW'(CLK_DIV / 2);
  localparam logic [TickW-1:0] TickLast = TickW'(OSR - 1);

  logic [DivW-1:0]  div_q, div_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic             sample_q, sample_d;
  logic             tick_edge;

  always_comb begin
    tick_edge      = advance_in && (div_q == DivLast);
    frame_edge_out = tick_edge && (tick_q == TickLast);
    div_d          = div_q;
    tick_d         = tick_q;
    if (clear_in) begin
      div_d  = '0;
      tick_d = '0;
    end else if (start_in) begin
      // Priming tick: the first frame edge lands exactly CLK_DIV cycles later.
      div_d  = '0;
      tick_d = TickLast;
    end else if (advance_in) begin
      div_d = tick_edge ? '0 : div_q + 1'b1;
      if (tick_edge) begin
        tick_d = frame_edge_out ? '0 : tick_q + 1'b1;
      end
    end
    sample_d = !clear_in && (start_in || advance_in) && (div_d < DivHalf);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q    <= '0;
      tick_q   <= '0;
      sample_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      tick_q   <= tick_d;
      sample_q <= sample_d;
    end
  end

  assign pdm_sample_out = sample_q;

endmodule

// File: rtl/pdm_sample_scheduler.sv
// One-deep PCM buffer and frame scheduler in front of a pdm modulator.
// Optional underrun counter output enabled by defining PDM_SCHED_UNDERRUN_CNT_EN.
module pdm_sample_scheduler
  import pdm_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = PDM_BIT_WIDTH,
  parameter int unsigned CLK_DIV   = PDM_CLK_DIV,
  parameter int unsigned OSR       = PDM_OSR
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        enable_in,
  pdm_sample_scheduler_if.slave       audio_bus,
  output logic                        pdm_sample_out,
  output logic signed [BIT_WIDTH-1:0] pdm_audio_out,
  output logic                        frame_start_out,
  output logic                        underrun_out,
  output logic                        running_out
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_count_out
`endif
);

  sched_state_t                state_q, state_d;
  logic signed [BIT_WIDTH-1:0] buf_q, buf_d, audio_q, audio_d;
  logic                        buf_full_q, buf_full_d;
  logic                        ready_q, ready_d;
  logic                        frame_start_q, frame_start_d;
  logic                        underrun_q, underrun_d;
  logic                        transfer, clear, start, advance, frame_edge;

  assign transfer = audio_bus.audio_valid_in && ready_q;
  assign clear    = (state_q == IDLE) || !enable_in;
  assign start    = (state_q == PRIME) && transfer && enable_in;
  assign advance  = (state_q == RUN) && enable_in;

  pdm_strobe_gen #(
    .CLK_DIV (CLK_DIV),
    .OSR     (OSR)
  ) u_strobe_gen (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .clear_in       (clear),
    .start_in       (start),
    .advance_in     (advance),
    .frame_edge_out (frame_edge),
    .pdm_sample_out (pdm_sample_out)
  );

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    audio_d       = audio_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    unique case (state_q)
      IDLE:    if (enable_in) state_d = PRIME;
      PRIME:   if (transfer) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (frame_edge) begin
      frame_start_d = 1'b1;
      if (buf_full_q) begin
        audio_d    = buf_q;
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
    // A transfer coinciding with an underrun frame waits for the next frame.
    if (transfer) begin
      buf_d      = audio_bus.audio_in;
      buf_full_d = 1'b1;
    end
    if (!enable_in) begin
      state_d       = IDLE;
      buf_full_d    = 1'b0;
      audio_d       = '0;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
    end
    ready_d = (state_d != IDLE) && !buf_full_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      audio_q       <= '0;
      ready_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      audio_q       <= audio_d;
      ready_q       <= ready_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign audio_bus.audio_ready_out = ready_q;
  assign pdm_audio_out             = audio_q;
  assign frame_start_out           = frame_start_q;
  assign underrun_out              = underrun_q;
  assign running_out               = (state_q == RUN);

`ifdef PDM_SCHED_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (state_d == IDLE) begin
      ucnt_d = '0;
    end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count_out = ucnt_q;
`endif

endmodule

// File: tb/tb_pdm_sample_scheduler.sv
// Scoreboard bench for pdm_sample_scheduler: frame loads, underruns, collision, disable.
module tb_pdm_sample_scheduler;

  localparam int unsigned Bw    = 24;
  localparam int          Limit = 20000;

  typedef struct packed {
    logic          underrun;
    logic [Bw-1:0] audio;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          enable_in;
  logic          pdm_sample_out;
  logic [Bw-1:0] pdm_audio_out;
  logic          frame_start_out;
  logic          underrun_out;
  logic          running_out;
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
  logic [15:0]   underrun_count_out;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  pdm_sample_scheduler_if #(.BIT_WIDTH(Bw)) bus ();

  pdm_sample_scheduler #(
    .BIT_WIDTH (Bw),
    .CLK_DIV   (32),
    .OSR       (128)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .enable_in          (enable_in),
    .audio_bus          (bus.slave),
    .pdm_sample_out     (pdm_sample_out),
    .pdm_audio_out      (pdm_audio_out),
    .frame_start_out    (frame_start_out),
    .underrun_out       (underrun_out),
    .running_out        (running_out)
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
    ,
    .underrun_count_out (underrun_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [Bw-1:0] s);
    int n = 0;
    @(negedge clk_in);
    bus.audio_in       = s;
    bus.audio_valid_in = 1'b1;
    while (!bus.audio_ready_out && n < Limit) begin
      @(negedge clk_in);
      n++;
    end
    check("send_accept", 32'(n < Limit), 1);
    sb.push_back({1'b0, s});
    @(negedge clk_in);
    bus.audio_valid_in = 1'b0;
  endtask

  // n = negedges until frame_start_out is seen; rdy = ready-high cycles before it.
  task automatic wait_frame(input string tag, output int n, output int rdy);
    n   = 0;
    rdy = 0;
    do begin
      @(negedge clk_in);
      n++;
      if (!frame_start_out && bus.audio_ready_out) rdy++;
    end while (!frame_start_out && n < Limit);
    check({tag, "_seen"}, 32'(frame_start_out), 1);
  endtask

  task automatic measure_strobe();
    int h = 0;
    int l = 0;
    int guard = 0;
    while (pdm_sample_out && guard < 100) begin @(negedge clk_in); guard++; end
    while (!pdm_sample_out && guard < 200) begin @(negedge clk_in); guard++; end
    while (pdm_sample_out && guard < 300) begin h++; @(negedge clk_in); guard++; end
    while (!pdm_sample_out && guard < 400) begin l++; @(negedge clk_in); guard++; end
    check("strobe_high", h, 16);
    check("strobe_period", h + l, 32);
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (frame_start_out) begin
      check("frame_pending", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("frame_audio", 32'(pdm_audio_out), 32'(e.audio));
        check("frame_underrun", 32'(underrun_out), 32'(e.underrun));
        check("frame_strobe_rise", 32'(pdm_sample_out), 1);
      end
    end
    check("underrun_stray", 32'(underrun_out && !frame_start_out), 0);
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    int n, rdy, hits;
    rst_in             = 1'b1;
    enable_in          = 1'b0;
    bus.audio_valid_in = 1'b0;
    bus.audio_in       = '0;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_sample", 32'(pdm_sample_out), 0);
    check("rst_audio", 32'(pdm_audio_out), 0);
    check("rst_frame", 32'(frame_start_out), 0);
    check("rst_underrun", 32'(underrun_out), 0);
    check("rst_running", 32'(running_out), 0);
    check("rst_ready", 32'(bus.audio_ready_out), 0);
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
    check("rst_ucnt", 32'(underrun_count_out), 0);
`endif
    rst_in = 1'b0;
    hits = 0;
    repeat (1000) begin
      @(negedge clk_in);
      if (pdm_sample_out || bus.audio_ready_out || running_out || frame_start_out) hits++;
    end
    check("idle_static", hits, 0);

    enable_in = 1'b1;
    @(negedge clk_in);
    check("prime_ready", 32'(bus.audio_ready_out), 1);
    check("prime_running", 32'(running_out), 0);

    // Streaming: each sample lands on its own frame, no underrun.
    send(24'h400000);
    check("run_entry", 32'(running_out), 1);
    wait_frame("first_frame", n, rdy);
    check("first_latency", n, 32);
    send(24'hC00000);
    measure_strobe();
    send(24'h000001);
    send(24'h123456);

    // Source stops: three empty frames repeat the last sample.
    repeat (3) sb.push_back({1'b1, 24'h123456});
    wait_frame("load_123456", n, rdy);
    wait_frame("underrun1", n, rdy);
    @(negedge clk_in);
    check("underrun_width", 32'(underrun_out), 0);
    wait_frame("underrun2", n, rdy);
    check("frame_spacing", n + 1, 4096);
    wait_frame("underrun3", n, rdy);
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
    check("ucnt_three", 32'(underrun_count_out), 3);
`endif

    // Collision: valid lands on the frame-edge cycle with an empty buffer.
    sb.push_back({1'b1, 24'h123456});
    sb.push_back({1'b0, 24'hABCDEF});
    repeat (4095) @(negedge clk_in);
    bus.audio_in       = 24'hABCDEF;
    bus.audio_valid_in = 1'b1;
    @(negedge clk_in);
    bus.audio_valid_in = 1'b0;
    check("collision_frame", 32'(frame_start_out), 1);
    check("collision_ready", 32'(bus.audio_ready_out), 0);
    wait_frame("collision_load", n, rdy);
    check("collision_spacing", n, 4096);
    check("collision_ready_low", rdy, 0);
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
    check("ucnt_four", 32'(underrun_count_out), 4);
`endif

    // Disable mid-frame with a sample waiting in the buffer.
    send(24'h0F0F0F);
    repeat (1600) @(negedge clk_in);
    enable_in = 1'b0;
    @(negedge clk_in);
    check("dis_running", 32'(running_out), 0);
    check("dis_sample", 32'(pdm_sample_out), 0);
    check("dis_audio", 32'(pdm_audio_out), 0);
    check("dis_ready", 32'(bus.audio_ready_out), 0);
    check("dis_frame", 32'(frame_start_out), 0);
    check("dis_pending", sb.size(), 1);
    sb.delete();
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
    check("dis_ucnt", 32'(underrun_count_out), 0);
`endif
    repeat (4) @(negedge clk_in);
    enable_in = 1'b1;
    @(negedge clk_in);
    check("reprime_ready", 32'(bus.audio_ready_out), 1);
    hits = 0;
    repeat (5000) begin
      @(negedge clk_in);
      if (pdm_sample_out || running_out || frame_start_out) hits++;
    end
    check("reprime_hold", hits, 0);
    send(24'h765432);
    wait_frame("reprime_frame", n, rdy);
    check("reprime_latency", n, 32);
    repeat (4) @(negedge clk_in);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
